// File: rtl/window_min_max.sv
// Streaming min/max bound generator: tracks the smallest and largest non-NaN
// sample over a window (or until flush) and hands the pair out through a
// one-entry result buffer so the next window can accumulate meanwhile.
module window_min_max #(
    parameter int unsigned BITS      = 16,
    parameter string       PRECISION = "HALF",
    parameter int unsigned WINDOW    = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [BITS-1:0]                  in_data,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [BITS-1:0]                  out_min,
    output logic [BITS-1:0]                  out_max,
    output logic [$clog2(WINDOW+1)-1:0]      out_count
);
    localparam int unsigned CW    = $clog2(WINDOW + 1);
    localparam int unsigned EXP_W = (PRECISION == "HALF") ? 5 : (PRECISION == "SINGLE") ? 8 : 11;
    localparam int unsigned MAN_W = BITS - 1 - EXP_W;
    localparam logic [CW-1:0] WIN_FULL = CW'(WINDOW);
    localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);
    localparam logic [BITS-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic {
        ACC_EMPTY = 1'b0,
        ACC_TRACK = 1'b1
    } acc_state_t;

    acc_state_t      r_state, w_state_nxt, w_upd_state;
    logic [BITS-1:0] r_min, r_max, w_upd_min, w_upd_max;
    logic [CW-1:0]   r_count, w_cnt_inc;
    logic            r_flush_pend, w_flush_pend_nxt;
    logic            r_out_valid;
    logic [BITS-1:0] r_out_min, r_out_max;
    logic [CW-1:0]   r_out_count;

    logic w_in_nan, w_lt, w_gt, w_buf_free, w_accept, w_flush_eff, w_close;

    assign out_valid = r_out_valid;
    assign out_min   = r_out_min;
    assign out_max   = r_out_max;
    assign out_count = r_out_count;

    assign w_in_nan   = (&in_data[BITS-2 -: EXP_W]) && (|in_data[MAN_W-1:0]);
    assign w_buf_free = !r_out_valid || out_ready;
    // Hold off the closing sample (or a pending flush) while the result buffer is occupied
    assign in_ready   = w_buf_free || !((r_count == WIN_LAST) || r_flush_pend);

    less_than #(.BITS(BITS), .PRECISION(PRECISION)) u_lt (
        .i_a    (in_data),
        .i_b    (r_min),
        .o_lt_c (w_lt)
    );

    greater_than #(.BITS(BITS), .PRECISION(PRECISION)) u_gt (
        .i_a    (in_data),
        .i_b    (r_max),
        .o_gt_c (w_gt)
    );

    // Next accumulator state, close decision and flush latch
    always_comb begin
        w_upd_state = r_state;
        w_upd_min   = r_min;
        w_upd_max   = r_max;
        w_accept    = in_valid && in_ready;
        w_cnt_inc   = r_count + CW'(w_accept);
        w_flush_eff = flush || r_flush_pend;
        w_close     = w_buf_free && ((w_cnt_inc == WIN_FULL) || (w_flush_eff && (w_cnt_inc != '0)));
        w_flush_pend_nxt = w_flush_eff && (w_cnt_inc != '0) && !w_close;
        if (w_accept && !w_in_nan) begin
            case (r_state)
                ACC_EMPTY: begin
                    w_upd_state = ACC_TRACK;
                    w_upd_min   = in_data;
                    w_upd_max   = in_data;
                end
                ACC_TRACK: begin
                    if (w_lt) w_upd_min = in_data;
                    if (w_gt) w_upd_max = in_data;
                end
                default: w_upd_state = ACC_EMPTY;
            endcase
        end
        w_state_nxt = w_close ? ACC_EMPTY : w_upd_state;
    end

    // Accumulator state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ACC_EMPTY;
        else       r_state <= w_state_nxt;
    end

    // Accumulator datapath and result buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_min        <= '0;
            r_max        <= '0;
            r_count      <= '0;
            r_flush_pend <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_min    <= '0;
            r_out_max    <= '0;
            r_out_count  <= '0;
        end else begin
            r_flush_pend <= w_flush_pend_nxt;
            if (w_close) begin
                r_min       <= '0;
                r_max       <= '0;
                r_count     <= '0;
                r_out_valid <= 1'b1;
                r_out_min   <= (w_upd_state == ACC_TRACK) ? w_upd_min : QNAN;
                r_out_max   <= (w_upd_state == ACC_TRACK) ? w_upd_max : QNAN;
                r_out_count <= w_cnt_inc;
            end else begin
                r_min   <= w_upd_min;
                r_max   <= w_upd_max;
                r_count <= w_cnt_inc;
                if (out_ready) r_out_valid <= 1'b0;
            end
        end
    end
endmodule

// Strict floating-point a < b; +0 and -0 compare equal, NaN operands give 0.
module less_than #(
    parameter int unsigned BITS      = 16,
    parameter string       PRECISION = "HALF"
) (
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    output logic            o_lt_c
);
    localparam int unsigned EXP_W = (PRECISION == "HALF") ? 5 : (PRECISION == "SINGLE") ? 8 : 11;
    localparam int unsigned MAN_W = BITS - 1 - EXP_W;

    logic            w_a_nan, w_b_nan;
    logic [BITS-2:0] w_a_mag, w_b_mag;

    assign w_a_nan = (&i_a[BITS-2 -: EXP_W]) && (|i_a[MAN_W-1:0]);
    assign w_b_nan = (&i_b[BITS-2 -: EXP_W]) && (|i_b[MAN_W-1:0]);
    assign w_a_mag = i_a[BITS-2:0];
    assign w_b_mag = i_b[BITS-2:0];

    // Sign-magnitude ordering
    always_comb begin
        o_lt_c = 1'b0;
        if (!(w_a_nan || w_b_nan) && !((w_a_mag == '0) && (w_b_mag == '0))) begin
            if (i_a[BITS-1] != i_b[BITS-1]) o_lt_c = i_a[BITS-1];
            else if (!i_a[BITS-1])          o_lt_c = (w_a_mag < w_b_mag);
            else                            o_lt_c = (w_a_mag > w_b_mag);
        end
    end
endmodule

// Strict floating-point a > b; +0 and -0 compare equal, NaN operands give 0.
module greater_than #(
    parameter int unsigned BITS      = 16,
    parameter string       PRECISION = "HALF"
) (
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    output logic            o_gt_c
);
    localparam int unsigned EXP_W = (PRECISION == "HALF") ? 5 : (PRECISION == "SINGLE") ? 8 : 11;
    localparam int unsigned MAN_W = BITS - 1 - EXP_W;

    logic            w_a_nan, w_b_nan;
    logic [BITS-2:0] w_a_mag, w_b_mag;

    assign w_a_nan = (&i_a[BITS-2 -: EXP_W]) && (|i_a[MAN_W-1:0]);
    assign w_b_nan = (&i_b[BITS-2 -: EXP_W]) && (|i_b[MAN_W-1:0]);
    assign w_a_mag = i_a[BITS-2:0];
    assign w_b_mag = i_b[BITS-2:0];

    // Sign-magnitude ordering
    always_comb begin
        o_gt_c = 1'b0;
        if (!(w_a_nan || w_b_nan) && !((w_a_mag == '0) && (w_b_mag == '0))) begin
            if (i_a[BITS-1] != i_b[BITS-1]) o_gt_c = i_b[BITS-1];
            else if (!i_a[BITS-1])          o_gt_c = (w_a_mag > w_b_mag);
            else                            o_gt_c = (w_a_mag < w_b_mag);
        end
    end
endmodule
